// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - RV32I OP/OP-IMM issue unit: decode, register file, ALU drive, writeback
module alu_issue_unit #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [3:0]      operation,
    input  logic [XLEN-1:0] alu_result,
    output logic            done,
    output logic            illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DECODE    = 2'd1;
    localparam logic [1:0] EXECUTE   = 2'd2;
    localparam logic [1:0] WRITEBACK = 2'd3;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    logic [1:0]      state;
    logic [31:0]     ir;
    logic            illegal_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] regs [NUM_REGS];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] dec_op2;
    logic [3:0]      dec_op;
    logic            dec_illegal;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    // x0 is hardwired to zero on every read port
    assign rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

    assign instr_ready = (state == IDLE);
    assign done        = (state == WRITEBACK);
    assign illegal     = done & illegal_q;

    // Decode the latched word into ALU operand2/operation and a legality flag
    always_comb begin
        dec_op2     = rs2_val;
        dec_op      = {1'b0, funct3};
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_op = {ir[30], funct3};
                if (!(funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    dec_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_op2 = {{(XLEN-12){ir[31]}}, ir[31:20]};
                case (funct3)
                    3'b001: begin
                        dec_op = 4'b0001;
                        if (funct7 != 7'b0000000)
                            dec_illegal = 1'b1;
                    end
                    3'b101: begin
                        dec_op = {ir[30], 3'b101};
                        if (funct7 != 7'b0000000 && funct7 != 7'b0100000)
                            dec_illegal = 1'b1;
                    end
                    // ADDI and the logical/compare immediates never take the bit-30 qualifier
                    default: dec_op = {1'b0, funct3};
                endcase
            end
            default: begin
                dec_op      = 4'b0000;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Sequencer: one state per cycle, accept only in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:      if (instr_valid) state <= DECODE;
                DECODE:    state <= EXECUTE;
                EXECUTE:   state <= WRITEBACK;
                default:   state <= IDLE;
            endcase
        end
    end

    // Capture the instruction word on the handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ir <= '0;
        else if (state == IDLE && instr_valid)
            ir <= instr;
    end

    // Register ALU inputs in DECODE so they stay stable through EXECUTE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            operand1  <= '0;
            operand2  <= '0;
            operation <= '0;
            illegal_q <= 1'b0;
        end else if (state == DECODE) begin
            operand1  <= rs1_val;
            operand2  <= dec_op2;
            operation <= dec_op;
            illegal_q <= dec_illegal;
        end
    end

    // Sample the combinational ALU result at the end of EXECUTE
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            result_q <= '0;
        else if (state == EXECUTE)
            result_q <= alu_result;
    end

    // Register file: cleared on reset, written at the end of WRITEBACK
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (state == WRITEBACK && !illegal_q && rd != 5'd0) begin
            regs[rd] <= result_q;
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - randomized self-checking bench for alu_issue_unit
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  operation;
    logic [31:0] alu_result;
    logic        done;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_regs [32];

    // observations from the last issued instruction
    bit          hs_ok;
    int          done_lat;
    bit          obs_ill;
    bit          obs_done_after;
    bit          ready_busy;
    logic [31:0] obs_op1;
    logic [31:0] obs_op2;
    logic [3:0]  obs_op;
    time         hs_time;

    alu_issue_unit dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .operand1(operand1), .operand2(operand2), .operation(operation),
        .alu_result(alu_result), .done(done), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // behavioural RV32I ALU
    always_comb begin
        case (operation)
            4'b0000: alu_result = operand1 + operand2;
            4'b1000: alu_result = operand1 - operand2;
            4'b0001: alu_result = operand1 << operand2[4:0];
            4'b0010: alu_result = {31'd0, $signed(operand1) < $signed(operand2)};
            4'b0011: alu_result = {31'd0, operand1 < operand2};
            4'b0100: alu_result = operand1 ^ operand2;
            4'b0101: alu_result = operand1 >> operand2[4:0];
            4'b1101: alu_result = $unsigned($signed(operand1) >>> operand2[4:0]);
            4'b0110: alu_result = operand1 | operand2;
            4'b0111: alu_result = operand1 & operand2;
            default: alu_result = 32'd0;
        endcase
    end

    // Architectural reference: what the instruction means, by mnemonic
    task automatic model(input logic [31:0] w, output bit known, output bit legal,
                         output logic [31:0] res, output logic [3:0] op, output logic [31:0] o2);
        logic [31:0] a, b, imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        a   = ref_regs[w[19:15]];
        b   = ref_regs[w[24:20]];
        imm = {{20{w[31]}}, w[31:20]};
        f3  = w[14:12];
        f7  = w[31:25];
        known = 1'b1; legal = 1'b1; res = 32'd0; op = 4'd0; o2 = b;
        if (w[6:0] == 7'h33) begin
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            op = {w[30], f3};
            case (f3)
                3'd0: res = w[30] ? a - b : a + b;
                3'd1: res = a << b[4:0];
                3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: res = (a < b) ? 32'd1 : 32'd0;
                3'd4: res = a ^ b;
                3'd5: res = w[30] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end else if (w[6:0] == 7'h13) begin
            o2 = imm;
            op = {1'b0, f3};
            case (f3)
                3'd0: res = a + imm;
                3'd1: begin legal = (f7 == 7'h00); res = a << imm[4:0]; end
                3'd2: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                3'd3: res = (a < imm) ? 32'd1 : 32'd0;
                3'd4: res = a ^ imm;
                3'd5: begin
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
                    op = {w[30], 3'b101};
                    res = w[30] ? $unsigned($signed(a) >>> imm[4:0]) : a >> imm[4:0];
                end
                3'd6: res = a | imm;
                default: res = a & imm;
            endcase
        end else begin
            known = 1'b0;
            legal = 1'b0;
        end
    endtask

    task automatic commit(input logic [31:0] w);
        bit known, legal;
        logic [31:0] res, o2;
        logic [3:0] op;
        model(w, known, legal, res, op, o2);
        if (legal && w[11:7] != 5'd0)
            ref_regs[w[11:7]] = res;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  f7;
        r = $urandom; rd = r[4:0]; rs1 = r[9:5]; rs2 = r[14:10]; f3 = r[17:15];
        r = $urandom; imm = r[11:0];
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[12]) ? 7'h20 : 7'h00;
        case ($urandom_range(0, 5))
            0, 1: return {f7, rs2, rs1, f3, rd, 7'h33};
            2, 3: begin
                if (f3 == 3'd1) imm[11:5] = 7'h00;
                else if (f3 == 3'd5) imm[11:5] = r[13] ? 7'h20 : 7'h00;
                return {imm, rs1, f3, rd, 7'h13};
            end
            4: return r[14] ? {7'h01, rs2, rs1, f3, rd, 7'h33}
                            : {7'h20, rs2, rs1, 3'b001, rd, 7'h13};
            default: return {imm, rs1, f3, rd, 7'h03};
        endcase
    endfunction

    // Drive one instruction from a negedge and record what the DUT did; ends on a negedge in IDLE
    task automatic issue(input logic [31:0] w, input bit hold);
        int n;
        hs_ok = 0; done_lat = 0; obs_ill = 0; ready_busy = 0; obs_done_after = 0;
        instr = w; instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        hs_ok = 1; hs_time = $time;
        for (int k = 1; k <= 6 && done_lat == 0; k++) begin
            @(negedge clk);
            if (!hold) instr_valid = 1'b0;
            if (instr_ready) ready_busy = 1;
            if (k == 2) begin
                obs_op1 = operand1; obs_op2 = operand2; obs_op = operation;
            end
            if (done) begin
                done_lat = k; obs_ill = illegal;
            end
        end
        @(negedge clk);
        obs_done_after = done;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b0 || illegal !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: done=%b illegal=%b required 0/0", done, illegal);
        end
        checks++;
        if (operand1 !== 0 || operand2 !== 0 || operation !== 0) begin
            errors++; $display("FAIL reset_alu_inputs: op1=%h op2=%h op=%b required zero", operand1, operand2, operation);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b required 1", instr_ready);
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); #1;
            checks++;
            if (dbg_data !== 32'd0) begin
                errors++; $display("FAIL reset_reg x%0d: got %h required 0", i, dbg_data);
            end
        end
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    endtask

    task automatic test_directed;
        // T1 ADDI x1,x0,-3
        issue(32'hFFD00093, 0); commit(32'hFFD00093);
        checks++;
        if (!hs_ok || done_lat != 3) begin
            errors++; $display("FAIL t1_latency: done at cycle %0d required 3 (hs=%0d)", done_lat, hs_ok);
        end
        checks++;
        if (obs_op2 !== 32'hFFFFFFFD || obs_op !== 4'b0000) begin
            errors++; $display("FAIL t1_operands: op2=%h op=%b required fffffffd/0000", obs_op2, obs_op);
        end
        dbg_addr = 5'd1; #1;
        checks++;
        if (dbg_data !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL t1_x1: got %h required fffffffd", dbg_data);
        end
        // T2 SRAI x2,x1,1
        issue(32'h4010D113, 0); commit(32'h4010D113);
        checks++;
        if (obs_op !== 4'b1101 || obs_op2[4:0] !== 5'd1 || obs_op1 !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL t2_operands: op=%b shamt=%0d op1=%h required 1101/1/fffffffd", obs_op, obs_op2[4:0], obs_op1);
        end
        dbg_addr = 5'd2; #1;
        checks++;
        if (dbg_data !== 32'hFFFFFFFE) begin
            errors++; $display("FAIL t2_x2: got %h required fffffffe", dbg_data);
        end
        // T3 SUB x3,x2,x1
        issue(32'h401101B3, 0); commit(32'h401101B3);
        checks++;
        if (obs_op !== 4'b1000) begin
            errors++; $display("FAIL t3_op: got %b required 1000", obs_op);
        end
        dbg_addr = 5'd3; #1;
        checks++;
        if (dbg_data !== 32'h00000001) begin
            errors++; $display("FAIL t3_x3: got %h required 00000001", dbg_data);
        end
        // T4 ADDI x0,x0,7
        issue(32'h00700013, 0); commit(32'h00700013);
        dbg_addr = 5'd0; #1;
        checks++;
        if (done_lat != 3 || obs_ill !== 1'b0 || dbg_data !== 32'd0) begin
            errors++; $display("FAIL t4_x0: done_at=%0d illegal=%b x0=%h required 3/0/0", done_lat, obs_ill, dbg_data);
        end
        // T5 illegal OP funct7/funct3 combination
        issue(32'h40001033, 0); commit(32'h40001033);
        checks++;
        if (done_lat != 3 || obs_ill !== 1'b1 || obs_done_after !== 1'b0) begin
            errors++; $display("FAIL t5_illegal: done_at=%0d illegal=%b done_after=%b required 3/1/0", done_lat, obs_ill, obs_done_after);
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); #1;
            checks++;
            if (dbg_data !== ref_regs[i]) begin
                errors++; $display("FAIL t5_reg x%0d: got %h required %h", i, dbg_data, ref_regs[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] w, res, o2, exp_op1;
        logic [3:0]  op;
        bit known, legal;
        for (int t = 0; t < 60; t++) begin
            w = rand_instr();
            exp_op1 = ref_regs[w[19:15]];
            model(w, known, legal, res, op, o2);
            issue(w, 0);
            commit(w);
            checks++;
            if (done_lat != 3 || obs_done_after !== 1'b0 || obs_ill !== !legal) begin
                errors++; $display("FAIL rand_done[%0d] %h: done_at=%0d after=%b illegal=%b required 3/0/%b", t, w, done_lat, obs_done_after, obs_ill, !legal);
            end
            checks++;
            if (obs_op1 !== exp_op1 || (known && (obs_op2 !== o2 || obs_op !== op))) begin
                errors++; $display("FAIL rand_alu_in[%0d] %h: op1=%h op2=%h op=%b required %h/%h/%b", t, w, obs_op1, obs_op2, obs_op, exp_op1, o2, op);
            end
            dbg_addr = w[11:7]; #1;
            checks++;
            if (dbg_data !== ref_regs[w[11:7]]) begin
                errors++; $display("FAIL rand_rd[%0d] %h: x%0d=%h required %h", t, w, w[11:7], dbg_data, ref_regs[w[11:7]]);
            end
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); #1;
            checks++;
            if (dbg_data !== ref_regs[i]) begin
                errors++; $display("FAIL rand_final x%0d: got %h required %h", i, dbg_data, ref_regs[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w;
        time prev;
        prev = 0;
        for (int t = 0; t < 8; t++) begin
            w = rand_instr();
            issue(w, 1);
            commit(w);
            checks++;
            if (ready_busy || done_lat != 3) begin
                errors++; $display("FAIL b2b_busy[%0d]: ready_while_busy=%b done_at=%0d required 0/3", t, ready_busy, done_lat);
            end
            if (t > 0) begin
                checks++;
                if (hs_time - prev != 40) begin
                    errors++; $display("FAIL b2b_spacing[%0d]: got %0t required 40", t, hs_time - prev);
                end
            end
            prev = hs_time;
            dbg_addr = w[11:7]; #1;
            checks++;
            if (dbg_data !== ref_regs[w[11:7]]) begin
                errors++; $display("FAIL b2b_rd[%0d]: x%0d=%h required %h", t, w[11:7], dbg_data, ref_regs[w[11:7]]);
            end
        end
    endtask

    task automatic test_reset_mid_instr;
        bit saw_done;
        int n;
        saw_done = 0;
        instr = 32'h00900293; instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || operand1 !== 0 || operand2 !== 0 || operation !== 0) begin
            errors++; $display("FAIL t6_async: done=%b op1=%h op2=%h op=%b required all zero", done, operand1, operand2, operation);
        end
        repeat (2) begin
            @(negedge clk);
            saw_done |= done;
        end
        reset = 1'b0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        repeat (4) begin
            @(negedge clk);
            saw_done |= done;
        end
        checks++;
        if (saw_done || instr_ready !== 1'b1) begin
            errors++; $display("FAIL t6_dropped: done_seen=%b ready=%b required 0/1", saw_done, instr_ready);
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); #1;
            checks++;
            if (dbg_data !== 32'd0) begin
                errors++; $display("FAIL t6_reg x%0d: got %h required 0", i, dbg_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_instr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
